// File: rtl/seg_scroll_buf_if.sv
// ---------------------------------------------------------------------------
// seg_scroll_buf_if
// Bundles the control, message-write and display signals of the
// seven-segment scroll buffer.
//
// Signals:
//   run      1 = prescaler counts and scrolling proceeds, 0 = hold
//   dir      1 = pointer increments (text moves left), 0 = decrements
//   clr      synchronous restart of pointer and prescaler
//   wr_en    message write strobe
//   wr_addr  message entry index (AW bits)
//   wr_data  4-bit digit code to store
//   dig3     leftmost displayed code  (msg[pos])
//   dig2     middle displayed code    (msg[pos+1])
//   dig1     rightmost displayed code (msg[pos+2])
//   pos      current scroll pointer
//   step     one-cycle pulse in the cycle after the pointer moved
//
// Modports:
//   master - drives control/write signals, observes display outputs
//   slave  - the scroll buffer itself
// ---------------------------------------------------------------------------
interface seg_scroll_buf_if #(
  parameter int AW = 3
);
  logic          run;
  logic          dir;
  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic [3:0]    dig3;
  logic [3:0]    dig2;
  logic [3:0]    dig1;
  logic [AW-1:0] pos;
  logic          step;

  modport master (
    output run, dir, clr, wr_en, wr_addr, wr_data,
    input  dig3, dig2, dig1, pos, step
  );

  modport slave (
    input  run, dir, clr, wr_en, wr_addr, wr_data,
    output dig3, dig2, dig1, pos, step
  );
endinterface

// File: rtl/seg_scroll_buf.sv
// ---------------------------------------------------------------------------
// seg_scroll_buf
// Message buffer and scroll sequencer for the 3-digit seven-segment display.
// Holds MSG_LEN 4-bit digit codes and a scroll pointer that advances once
// every 2^DIV_W enabled clocks. Three consecutive message entries starting
// at the pointer (wrapping around the message) are presented, registered,
// to the per-digit seven-segment decoders.
//
// Parameters:
//   DIV_W    prescaler width; one scroll step every 2^DIV_W enabled clocks
//   MSG_LEN  number of message entries (3..16)
//   AW       pointer/address width, 2^AW >= MSG_LEN
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   seg_scroll_buf_if.slave (run/dir/clr, message write port,
//         dig3/dig2/dig1 display codes, pos, step)
// ---------------------------------------------------------------------------
module seg_scroll_buf #(
  parameter int DIV_W   = 24,
  parameter int MSG_LEN = 6,
  parameter int AW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  seg_scroll_buf_if.slave bus
);

  localparam logic [AW:0] MSG_LEN_W = (AW+1)'(MSG_LEN);
  localparam logic [AW:0] ONE_W     = (AW+1)'(1);
  localparam logic [AW:0] TWO_W     = (AW+1)'(2);
  localparam logic [AW:0] BACK_W    = (AW+1)'(MSG_LEN - 1);

  logic [3:0]       msg [MSG_LEN];
  logic [DIV_W-1:0] presc;
  logic [AW-1:0]    pos_q;
  logic             step_q;
  logic [3:0]       dig3_q;
  logic [3:0]       dig2_q;
  logic [3:0]       dig1_q;
  logic             scroll_evt;
  logic             wr_ok;

  // Modular index: (base + off) mod MSG_LEN, computed one bit wider than the
  // pointer so a single conditional subtract suffices for any MSG_LEN.
  // Stepping backwards is done by adding MSG_LEN-1.
  function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] base,
                                            input logic [AW:0]   off);
    logic [AW:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= MSG_LEN_W)
      sum = sum - MSG_LEN_W;
    return sum[AW-1:0];
  endfunction

  // clr suppresses the scroll event even when the prescaler is about to wrap.
  assign scroll_evt = bus.run && !bus.clr && (presc == '1);
  assign wr_ok      = bus.wr_en && ({1'b0, bus.wr_addr} < MSG_LEN_W);

  // Prescaler and scroll pointer; clr takes priority over run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      pos_q  <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= scroll_evt;
      if (bus.clr) begin
        presc <= '0;
        pos_q <= '0;
      end else begin
        if (bus.run)
          presc <= presc + 1'b1;
        if (scroll_evt)
          pos_q <= bus.dir ? add_mod(pos_q, ONE_W) : add_mod(pos_q, BACK_W);
      end
    end
  end

  // Message store; out-of-range addresses are dropped, writes ignore run/clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++)
        msg[i] <= 4'hF;
    end else if (wr_ok) begin
      msg[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Display registers sample the pointer and message as they stand before
  // the edge, so any pointer/message update shows up one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig3_q <= 4'hF;
      dig2_q <= 4'hF;
      dig1_q <= 4'hF;
    end else begin
      dig3_q <= msg[pos_q];
      dig2_q <= msg[add_mod(pos_q, ONE_W)];
      dig1_q <= msg[add_mod(pos_q, TWO_W)];
    end
  end

  assign bus.dig3 = dig3_q;
  assign bus.dig2 = dig2_q;
  assign bus.dig1 = dig1_q;
  assign bus.pos  = pos_q;
  assign bus.step = step_q;

endmodule

// File: tb/tb_seg_scroll_buf.sv
// ---------------------------------------------------------------------------
// tb_seg_scroll_buf
// Self-checking bench for seg_scroll_buf with DIV_W=2, MSG_LEN=6, AW=3.
// A cycle-level reference model (message array, pointer and prescaler kept
// as plain integers with modulo arithmetic) predicts the display outputs.
// ---------------------------------------------------------------------------
module tb_seg_scroll_buf;

  localparam int DIV_W   = 2;
  localparam int MSG_LEN = 6;
  localparam int AW      = 3;
  localparam int PERIOD  = 1 << DIV_W;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seg_scroll_buf_if #(.AW(AW)) bus ();

  seg_scroll_buf #(
    .DIV_W  (DIV_W),
    .MSG_LEN(MSG_LEN),
    .AW     (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_msg [16];
  int m_pos;
  int m_presc;
  int m_step;
  int m_d3;
  int m_d2;
  int m_d1;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_msg[i] = 15;
    m_pos = 0; m_presc = 0; m_step = 0;
    m_d3 = 15; m_d2 = 15; m_d1 = 15;
  endfunction

  // One rising edge: display shows what the pointer selected before the edge.
  function automatic void model_edge(input bit run, input bit dir, input bit clr,
                                     input bit we, input int wa, input int wd);
    bit evt;
    evt  = run && !clr && (m_presc == PERIOD - 1);
    m_d3 = m_msg[m_pos];
    m_d2 = m_msg[(m_pos + 1) % MSG_LEN];
    m_d1 = m_msg[(m_pos + 2) % MSG_LEN];
    m_step = evt;
    if (clr) begin
      m_pos = 0;
      m_presc = 0;
    end else begin
      if (run) m_presc = (m_presc + 1) % PERIOD;
      if (evt) m_pos = dir ? (m_pos + 1) % MSG_LEN : (m_pos + MSG_LEN - 1) % MSG_LEN;
    end
    if (we && wa < MSG_LEN) m_msg[wa] = wd;
  endfunction

  function automatic logic [15:0] exp_vec();
    return {4'(m_d3), 4'(m_d2), 4'(m_d1), 3'(m_pos), 1'(m_step)};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {bus.dig3, bus.dig2, bus.dig1, bus.pos, bus.step};
  endfunction

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic cycle();
    bit r, d, c, w;
    int a, v;
    r = bus.run; d = bus.dir; c = bus.clr; w = bus.wr_en;
    a = int'(bus.wr_addr); v = int'(bus.wr_data);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(r, d, c, w, a, v);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.run = 1'b0; bus.dir = 1'b1; bus.clr = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== {4'hF, 4'hF, 4'hF, 3'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", obs_vec(), {4'hF, 4'hF, 4'hF, 3'd0, 1'b0});
    end
    repeat (2) cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_load();
    for (int a = 0; a < MSG_LEN; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = 4'(a + 1);
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL load_write %0d: got %h expected %h", a, obs_vec(), exp_vec());
      end
    end
    bus.wr_en = 1'b0;
    cycle();
    checks++;
    if ({bus.dig3, bus.dig2, bus.dig1, bus.pos} !== {4'h1, 4'h2, 4'h3, 3'd0}) begin
      errors++;
      $display("[TB] FAIL load_digits: got %h%h%h pos %0d expected 123 pos 0",
               bus.dig3, bus.dig2, bus.dig1, bus.pos);
    end
  endtask

  task automatic test_scroll_up();
    int steps;
    steps = 0;
    bus.run = 1'b1; bus.dir = 1'b1;
    for (int i = 0; i < 6 * PERIOD; i++) begin
      cycle();
      if (bus.step === 1'b1) steps++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL scroll_up cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (steps != 6 || bus.pos !== 3'd0) begin
      errors++;
      $display("[TB] FAIL scroll_up_wrap: got %0d steps pos %0d expected 6 steps pos 0", steps, bus.pos);
    end
  endtask

  task automatic test_scroll_down();
    bus.dir = 1'b0;
    for (int i = 0; i < PERIOD; i++) cycle();
    checks++;
    if (bus.pos !== 3'd5 || bus.step !== 1'b1) begin
      errors++;
      $display("[TB] FAIL scroll_down_wrap: got pos %0d step %b expected pos 5 step 1", bus.pos, bus.step);
    end
    // dir wiggles freely between events; only its value at the event edge counts
    for (int i = 0; i < PERIOD; i++) begin
      bus.dir = (i == PERIOD - 1) ? 1'b0 : 1'($urandom);
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL scroll_down cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    cycle();
    checks++;
    if ({bus.dig3, bus.dig2, bus.dig1, bus.pos} !== {4'h5, 4'h6, 4'h1, 3'd4}) begin
      errors++;
      $display("[TB] FAIL scroll_down_digits: got %h%h%h pos %0d expected 561 pos 4",
               bus.dig3, bus.dig2, bus.dig1, bus.pos);
    end
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 400; i++) begin
      bus.run     = ($urandom_range(0, 4) != 0);
      bus.dir     = 1'($urandom);
      bus.clr     = ($urandom_range(0, 15) == 0);
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = AW'($urandom_range(0, 7));
      bus.wr_data = 4'($urandom);
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random_mix cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    bus.clr = 1'b0; bus.wr_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    bit done;
    bus.run = 1'b0; bus.dir = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = (a < MSG_LEN) ? 4'(a + 1) : 4'h0;
      cycle();
    end
    bus.wr_en = 1'b0;
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    bus.run = 1'b1;
    n = 0;
    while (!(m_pos == 2 && m_presc == PERIOD - 1) && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL b2b_reach_pos2: got timeout expected pos 2 within 100 cycles");
    end
    bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 4'h9;
    cycle();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.pos !== 3'd3 || bus.step !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_event: got pos %0d step %b expected pos 3 step 1", bus.pos, bus.step);
    end
    cycle();
    checks++;
    if ({bus.dig3, bus.dig2, bus.dig1} !== {4'h4, 4'h9, 4'h6}) begin
      errors++;
      $display("[TB] FAIL b2b_digits: got %h%h%h expected 496", bus.dig3, bus.dig2, bus.dig1);
    end
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    checks++;
    if (bus.pos !== 3'd0 || bus.step !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_pos: got pos %0d step %b expected pos 0 step 0", bus.pos, bus.step);
    end
    n = 0; done = 1'b0;
    while (!done && n < 10) begin
      cycle();
      n++;
      if (n == 1) begin
        checks++;
        if ({bus.dig3, bus.dig2, bus.dig1} !== {4'h1, 4'h2, 4'h3}) begin
          errors++;
          $display("[TB] FAIL clr_digits: got %h%h%h expected 123", bus.dig3, bus.dig2, bus.dig1);
        end
      end
      if (bus.step === 1'b1) done = 1'b1;
    end
    checks++;
    if (n != PERIOD || !done) begin
      errors++;
      $display("[TB] FAIL clr_to_step: got %0d cycles expected %0d", n, PERIOD);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit done;
    bus.run = 1'b1; bus.dir = 1'b1;
    repeat (5) cycle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== {4'hF, 4'hF, 4'hF, 3'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", obs_vec(), {4'hF, 4'hF, 4'hF, 3'd0, 1'b0});
    end
    repeat (2) cycle();
    rst = 1'b0;
    n = 0; done = 1'b0;
    while (!done && n < 10) begin
      cycle();
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL post_reset cyc %0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
      if (bus.step === 1'b1) done = 1'b1;
    end
    checks++;
    if (n != PERIOD || !done || bus.pos !== 3'd1) begin
      errors++;
      $display("[TB] FAIL reset_to_step: got %0d cycles pos %0d expected %0d cycles pos 1", n, bus.pos, PERIOD);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load();
    test_scroll_up();
    test_scroll_down();
    test_random_mix();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scroll_buf.md
Name: seg_scroll_buf

Overview:
Message buffer and scroll sequencer for the 3-digit seven-segment board display. It holds an MSG_LEN-entry message of 4-bit digit codes and a scroll pointer. The pointer advances on an internal prescaled tick. It presents three consecutive message codes (wrapping) to the downstream per-digit seven-segment decoders. It replaces a hard-coded count-to-pattern case table with a loadable, direction-controllable scroller.

Parameters:
DIV_W, 24, prescaler width; one scroll step every 2^DIV_W enabled clocks
MSG_LEN, 6, number of message entries (legal range 3..16)
AW, 3, address/pointer width; must satisfy 2^AW >= MSG_LEN

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
run  input  1  1 = prescaler counts and scrolling proceeds; 0 = hold
dir  input  1  1 = pointer increments (text moves left); 0 = pointer decrements
clr  input  1  synchronous restart: pointer and prescaler to 0; message untouched
wr_en  input  1  message write strobe
wr_addr  input  AW  message entry index
wr_data  input  4  digit code to store (0-9 numeric, A-F passed through; F = blank by decoder convention)
dig3  output  4  code at msg[pos] (leftmost digit)
dig2  output  4  code at msg[(pos+1) mod MSG_LEN]
dig1  output  4  code at msg[(pos+2) mod MSG_LEN] (rightmost digit)
pos  output  AW  current scroll pointer
step  output  1  one-cycle pulse, registered, high in the cycle after the pointer moved

Behaviour:
- Reset (async, rst=1): all message entries = 4'hF; pos = 0; prescaler = 0; step = 0; dig3/dig2/dig1 = 4'hF. Outputs are held while rst = 1.
- Prescaler: DIV_W-bit counter.
  - Increments each clk while run=1 and clr=0.
  - Holds when run=0.
  - A scroll event occurs on the edge where prescaler = all-ones and run=1. The prescaler wraps to 0 on that edge.
- Pointer update on a scroll event:
  - dir=1: pos = pos+1, and MSG_LEN-1 wraps to 0.
  - dir=0: pos = pos-1, and 0 wraps to MSG_LEN-1.
  - dir is sampled only on the scroll-event edge. A dir change between events has no other effect.
- step: registered. It is 1 for exactly the one cycle following a scroll-event edge, otherwise 0. It is never asserted for clr or writes.
- clr=1: pos = 0 and prescaler = 0 on the next edge. No scroll event occurs that cycle, even if the prescaler was all-ones. clr has priority over run. Message contents are unaffected.
- Writes: when wr_en=1 and wr_addr < MSG_LEN, msg[wr_addr] = wr_data on the edge. When wr_addr >= MSG_LEN, the write is ignored. Writes are accepted regardless of run/clr.
- Display outputs: dig3/dig2/dig1 are registered from the current pos and message array. Latency is 1 clock after any pos or message change becomes visible in the registers.
- Simultaneous write + scroll event: both commit on the same edge. The outputs one cycle later reflect the new pos and the new data.
- Index arithmetic: use modular addition on AW+1 bits with a conditional subtract of MSG_LEN. No power-of-two assumption.
- Async reset mid-scroll: the state is abandoned and all values return to their reset values immediately. Scrolling resumes from pos 0 after rst deasserts, with a full 2^DIV_W-cycle wait to the first step.

Test Plan:
- DIV_W=2, MSG_LEN=6. Assert rst with run=0 -> dig3/dig2/dig1 = F/F/F, pos=0, step=0. Hold run=0 for 10 cycles -> no change.
- Load codes 1,2,3,4,5,6 into addr 0-5, run=0 -> one cycle after the last write, dig3/2/1 = 1/2/3, pos=0.
- run=1, dir=1 -> step pulses every 4 clocks. Sequence pos 1:2/3/4, 2:3/4/5, 3:4/5/6, 4:5/6/1, 5:6/1/2, then wrap to pos 0:1/2/3.
- From pos 0, set dir=0 -> next step gives pos=5 (6/1/2), then pos=4 (5/6/1). Toggle dir mid-interval -> only the value at the event edge is used.
- At pos 2, on the scroll-event edge write addr 4 = 9 and assert clr in a later cycle -> after the event, pos=3 and digits 4/9/6. After clr, pos=0, digits 1/2/3, and the next step occurs exactly 4 clocks after clr.
- Write wr_addr=7 (>= MSG_LEN) -> no entry changes. Assert rst mid-interval -> digits F/F/F immediately and pos=0.
